hw_timer: RTL and testbench
===========================

# hw_timer

Programmable memory-mapped down-counter that generates the hardware interrupt request consumed by the coprocessor-0 exception unit. It sits on the CPU's peripheral bus, holds three 32-bit registers (CTRL, PRESET, COUNT), and drives `IRQ` into `HWInt[0]`, the lowest-priority hardware interrupt line of CP0. It supports one-shot and periodic modes and has an interrupt mask.

## Interface
- `PRESCALE`, default 4: clock divider for count ticks. Used only when `TIMER_PRESCALE_EN` is defined. Legal range is 1..65535.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `Addr`  in  [3:2]  word select: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved (reads 0).
- `We`  in  1  write enable, sampled at the rising edge.
- `Din`  in  32  write data.
- `Dout`  out  32  combinational read data for `Addr`.
- `IRQ`  out  1  interrupt request to CP0 `HWInt[0]`.

## Operation
- **CTRL register**
  - Only bits [3:0] are stored; the other bits read 0.
  - [0] `En`: enable.
  - [2:1] `Mode`: 00 = one-shot, 01 = periodic, 1x = treated as one-shot.
  - [3] `IM`: interrupt mask.
- **PRESET**: 32-bit reload value, read/write.
- **COUNT**: 32-bit, read-only. Writes to COUNT or reserved addresses are ignored.
- **Reset values**: CTRL = 0, PRESET = 0, COUNT = 0, state = IDLE, `pend` = 0, `IRQ` = 0, and `Dout` = 0 for every address.
- **Interrupt output**: `IRQ = IM & pend`.
- **FSM (state, then transitions)**
  - IDLE: if `En` = 1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If `En` = 0, go to IDLE; COUNT holds its value.
    - Else if COUNT = 0, go to INT and set `pend` on the same edge.
    - Else, on a tick, COUNT <= COUNT - 1.
  - INT, one-shot mode: clear `En`, go to IDLE; `pend` stays set.
  - INT, periodic mode: clear `pend`, go to LOAD.
- **Clearing `pend`**
  - Any write to CTRL or PRESET clears `pend`.
  - In periodic mode, `pend` is also cleared on leaving INT, so `IRQ` is a 1-cycle pulse.
  - In one-shot mode, `IRQ` stays high until software clears it.
- **Boundary conditions**
  - PRESET = 0: the timer enters INT one cycle after LOAD.
  - COUNT never wraps; 0 is terminal.
  - A CTRL write in the same cycle as INT clearing `En`: the bus write wins.
  - A PRESET write during CNT: COUNT is unaffected; the new value takes effect at the next LOAD.
  - Re-enabling after a disable always passes through LOAD, i.e. COUNT reloads.
  - `rst_n` low mid-count: all state returns to reset values immediately; `IRQ` drops without waiting for a clock.

## Timing
- Edge numbering: CTRL write with `En` = 1 and PRESET = N at edge e0.
  - e1: LOAD
  - e2: COUNT = N, CNT
  - e2+N: COUNT = 0
  - e3+N: INT, `IRQ` high (if `IM` = 1)
- Total latency from the enabling write to `IRQ` is N+3 cycles, without prescaling.
- Periodic mode: period N+3 cycles, `IRQ` high for 1 cycle.
- One-shot mode: at e4+N the state is IDLE and `En` = 0; `IRQ` stays high.
- `Dout` is combinational, so a read returns the value present after the last edge.
- CP0 samples `IRQ` combinationally through `HWInt`. `IRQ` is registered-derived (a flop AND a register bit), so it is glitch-free.

## Configuration
- **`TIMER_PRESCALE_EN` defined**
  - A prescaler counter of width ceil(log2(PRESCALE)) resets to 0 in LOAD.
  - It asserts a tick once every PRESCALE cycles while in CNT.
  - CNT then lasts N×PRESCALE+1 cycles; latency from the enabling write to `IRQ` = N×PRESCALE+3.
- **Not defined**: tick = 1 every cycle; `PRESCALE` is ignored; the latencies in Timing apply.

## Test plan
- **Reset**: hold `rst_n` = 0, then release. All reads return 0 and `IRQ` = 0. Then assert `rst_n` low mid-count with `IRQ` = 1 → `IRQ` = 0 before the next edge.
- **One-shot**: PRESET = 5, then CTRL = 0x9 (`IM`, one-shot, `En`).
  - `IRQ` rises exactly 8 cycles after the CTRL write edge and stays high.
  - CTRL reads 0x8.
  - Writing CTRL = 0x8 drops `IRQ` on the next edge.
- **Periodic**: PRESET = 3, CTRL = 0xB. `IRQ` pulses 1 cycle wide, every 6 cycles, 4 consecutive times.
- **Masked / disabled**
  - CTRL = 0x3: no `IRQ` ever, while COUNT still cycles 3→0.
  - With COUNT = 2, write CTRL `En` = 0: COUNT holds 2.
  - Re-enable: COUNT reloads to PRESET.
- **Edge cases**
  - PRESET = 0 with `En` = 1 → `IRQ` 3 cycles after the write.
  - A PRESET write during CNT does not change COUNT.
  - A CTRL write colliding with INT → the written `En` value is retained.
  - Writes to COUNT and address 3 are ignored.
- **Prescaler** (with `TIMER_PRESCALE_EN`, `PRESCALE` = 4): PRESET = 2, one-shot → `IRQ` 11 cycles after the enabling write.

Source files
------------

// File: rtl/hw_timer.sv
// hw_timer
//   Memory-mapped 32-bit down-counter that raises the lowest-priority
//   hardware interrupt line of the CP0 exception unit. Supports one-shot and
//   periodic operation plus an interrupt mask.
//
//   Register map (word select Addr[3:2]):
//     0 CTRL    [0] En, [2:1] Mode (01 periodic, otherwise one-shot), [3] IM
//     1 PRESET  32-bit reload value
//     2 COUNT   32-bit current count, read-only
//     3 reserved, reads 0, writes ignored
//
//   Optional build macro: TIMER_PRESCALE_EN
//     When defined, COUNT decrements once every PRESCALE cycles instead of
//     every cycle. When undefined, PRESCALE has no effect.
//
// Ports
//   clk    in   system clock, rising-edge
//   rst_n  in   asynchronous active-low reset
//   Addr   in   [3:2] register word select
//   We     in   write enable
//   Din    in   [31:0] write data
//   Dout   out  [31:0] combinational read data
//   IRQ    out  interrupt request (IM & pend)
//
// FSM
//   state  | meaning
//   IDLE   | timer stopped, waiting for En
//   LOAD   | COUNT <= PRESET, prescaler cleared
//   CNT    | counting down toward 0
//   INT    | terminal count reached, pend set; reload or stop by mode
module hw_timer #(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:2]  Addr,
  input  logic        We,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  state_t      state;
  state_t      state_nxt;

  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        pend;

  logic        ctrl_en;
  logic        ctrl_im;
  logic        periodic;

  logic        wr_ctrl;
  logic        wr_preset;

  logic        load_cnt;
  logic        run_cnt;
  logic        dec_cnt;
  logic        set_pend;
  logic        clr_pend_int;
  logic        clr_en;
  logic        tick;

  assign ctrl_en  = ctrl[0];
  assign periodic = (ctrl[2:1] == 2'b01);
  assign ctrl_im  = ctrl[3];

  assign wr_ctrl   = We && (Addr == ADDR_CTRL);
  assign wr_preset = We && (Addr == ADDR_PRESET);

`ifdef TIMER_PRESCALE_EN
  // A PRESCALE of 1 would give a zero-width counter; keep at least one bit
  // and let the compare against 0 tick every cycle.
  localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (load_cnt) begin
      pre_cnt <= '0;
    end else if (run_cnt) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end
`else
  logic unused_prescale;

  assign unused_prescale = (PRESCALE != 0);
  assign tick            = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    load_cnt     = 1'b0;
    run_cnt      = 1'b0;
    dec_cnt      = 1'b0;
    set_pend     = 1'b0;
    clr_pend_int = 1'b0;
    clr_en       = 1'b0;
    case (state)
      S_IDLE: begin
        if (ctrl_en) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        load_cnt  = 1'b1;
        state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_en) begin
          state_nxt = S_IDLE;
        end else if (count == 32'd0) begin
          set_pend  = 1'b1;
          state_nxt = S_INT;
        end else begin
          run_cnt = 1'b1;
          dec_cnt = tick;
        end
      end
      S_INT: begin
        if (periodic) begin
          clr_pend_int = 1'b1;
          state_nxt    = S_LOAD;
        end else begin
          clr_en    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // A software write to CTRL takes priority over the one-shot auto-clear
  // of En, so software can re-arm in the very cycle the timer expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= 4'd0;
    end else if (wr_ctrl) begin
      ctrl <= Din[3:0];
    end else if (clr_en) begin
      ctrl[0] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preset <= 32'd0;
    end else if (wr_preset) begin
      preset <= Din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (load_cnt) begin
      count <= preset;
    end else if (dec_cnt) begin
      count <= count - 32'd1;
    end
  end

  // Reaching terminal count wins over a coincident register write so an
  // expiry is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else if (set_pend) begin
      pend <= 1'b1;
    end else if (wr_ctrl || wr_preset || clr_pend_int) begin
      pend <= 1'b0;
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (Addr)
      ADDR_CTRL:   Dout = {28'd0, ctrl};
      ADDR_PRESET: Dout = preset;
      ADDR_COUNT:  Dout = count;
      default:     Dout = 32'd0;
    endcase
  end

  // Both operands come straight from flops, so CP0 sees a clean level.
  assign IRQ = ctrl_im & pend;

endmodule

// File: tb/tb_hw_timer.sv
module tb_hw_timer;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_PRE  = 2'd1;
  localparam logic [1:0] A_CNT  = 2'd2;
  localparam logic [1:0] A_RSV  = 2'd3;

  typedef struct {
    logic        lvl;
    int          cyc;
  } irq_ev_t;

  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
  } rd_ev_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  Addr;
  logic        We;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int          cyc;
  int          n_cmp;
  int          n_mis;
  logic        rd_req;
  logic        mon_en;
  logic        irq_prev;

  irq_ev_t     irq_q[$];
  rd_ev_t      rd_q[$];

  hw_timer #(.PRESCALE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Addr  (Addr),
    .We    (We),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: register reads and IRQ transitions.
  initial irq_prev = 1'b0;
  always @(negedge clk) begin
    if (rd_req) begin
      if (rd_q.size() == 0) begin
        chk("read_without_expectation", Dout, 32'hDEAD_BEEF ^ Dout ^ 32'h1);
      end else begin
        rd_ev_t r;
        r = rd_q.pop_front();
        chk($sformatf("read_addr%0d", r.a), Dout, r.d);
      end
    end
    if (mon_en && (IRQ !== irq_prev)) begin
      if (irq_q.size() == 0) begin
        chk("irq_unexpected_edge", 32'(IRQ), 32'(irq_prev));
      end else begin
        irq_ev_t e;
        e = irq_q.pop_front();
        chk("irq_level", 32'(IRQ), 32'(e.lvl));
        chk("irq_edge_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    irq_prev <= IRQ;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    We   = 1'b1;
    Din  = d;
    @(posedge clk);
    #1;
    We   = 1'b0;
    Din  = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e);
    rd_ev_t r;
    r.a = a;
    r.d = e;
    rd_q.push_back(r);
    Addr   = a;
    rd_req = 1'b1;
    @(negedge clk);
    #1;
    rd_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_irq(input logic lvl, input int c);
    irq_ev_t e;
    e.lvl = lvl;
    e.cyc = c;
    irq_q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    n_cmp  = 0;
    n_mis  = 0;
    rst_n  = 1'b0;
    Addr   = A_CTRL;
    We     = 1'b0;
    Din    = 32'd0;
    rd_req = 1'b0;
    mon_en = 1'b1;

    // Reset state
    #2;
    chk("irq_in_reset", 32'(IRQ), 32'd0);
    chk("dout_in_reset", Dout, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(A_CTRL, 32'd0);
    rd(A_PRE,  32'd0);
    rd(A_CNT,  32'd0);
    rd(A_RSV,  32'd0);

    // One-shot, PRESET = 5: IRQ 8 cycles after the write, held until cleared
    wr(A_PRE, 32'd5);
    wr(A_CTRL, 32'h9);
    e0 = cyc;
    exp_irq(1'b1, e0 + 8);
    idle(10);
    rd(A_CTRL, 32'h8);
    rd(A_CNT,  32'd0);
    exp_irq(1'b0, cyc + 1);
    wr(A_CTRL, 32'h8);

    // Periodic, PRESET = 3: four 1-cycle pulses every 6 cycles
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'hB);
    e0 = cyc;
    for (int k = 1; k <= 4; k++) begin
      exp_irq(1'b1, e0 + 6 * k);
      exp_irq(1'b0, e0 + 6 * k + 1);
    end
    idle(26);
    wr(A_CTRL, 32'h0);

    // Masked periodic: COUNT cycles 3..0 and reloads, no IRQ
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'h3);
    e0 = cyc;
    idle(2);
    rd(A_CNT, 32'd3);
    rd(A_CNT, 32'd2);
    rd(A_CNT, 32'd1);
    rd(A_CNT, 32'd0);
    rd(A_CNT, 32'd0);
    rd(A_CNT, 32'd0);
    // Disable on the edge that takes COUNT to 2; it must hold there
    wr(A_CTRL, 32'h2);
    rd(A_CNT, 32'd2);
    idle(3);
    rd(A_CNT, 32'd2);
    // Re-enable reloads from PRESET
    wr(A_CTRL, 32'h1);
    idle(2);
    rd(A_CNT, 32'd3);
    idle(6);

    // PRESET = 0: IRQ 3 cycles after the enabling write
    wr(A_PRE, 32'd0);
    wr(A_CTRL, 32'h9);
    e0 = cyc;
    exp_irq(1'b1, e0 + 3);
    idle(4);
    exp_irq(1'b0, cyc + 1);
    wr(A_CTRL, 32'h8);

    // PRESET write during CNT leaves COUNT alone
    wr(A_PRE, 32'd10);
    wr(A_CTRL, 32'h9);
    e0 = cyc;
    idle(2);
    wr(A_PRE, 32'd20);
    rd(A_CNT, 32'd9);
    rd(A_PRE, 32'd20);
    exp_irq(1'b1, e0 + 13);
    idle(8);
    // CTRL write on the same edge INT clears En: written En survives
    exp_irq(1'b0, e0 + 14);
    wr(A_CTRL, 32'h9);
    rd(A_CTRL, 32'h9);
    rd(A_CNT, 32'd0);
    rd(A_CNT, 32'd20);
    exp_irq(1'b1, e0 + 37);
    idle(22);

    // Writes to COUNT and reserved are ignored and do not clear pend
    wr(A_CNT, 32'h1234);
    wr(A_RSV, 32'hFFFF);
    rd(A_CNT, 32'd0);
    rd(A_RSV, 32'd0);
    rd(A_CTRL, 32'h8);
    rd(A_PRE, 32'd20);
    exp_irq(1'b0, cyc + 1);
    wr(A_PRE, 32'd2);

`ifdef TIMER_PRESCALE_EN
    // PRESCALE = 4, PRESET = 2: IRQ 11 cycles after the enabling write
    wr(A_CTRL, 32'h9);
    e0 = cyc;
    exp_irq(1'b1, e0 + 11);
    idle(12);
    exp_irq(1'b0, cyc + 1);
    wr(A_CTRL, 32'h8);
`endif

    // Asynchronous reset while IRQ is high
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'hB);
    e0 = cyc;
    exp_irq(1'b1, e0 + 6);
    idle(6);
    @(negedge clk);
    #1;
    chk("irq_high_before_reset", 32'(IRQ), 32'd1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("irq_async_drop", 32'(IRQ), 32'd0);
    Addr = A_CTRL;
    #1;
    chk("ctrl_async_clear", Dout, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    rd(A_CTRL, 32'd0);
    rd(A_PRE,  32'd0);
    rd(A_CNT,  32'd0);
    idle(10);

    chk("irq_queue_drained", 32'(irq_q.size()), 32'd0);
    chk("read_queue_drained", 32'(rd_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
